// File: rtl/usd_spi_if.sv
// Host-side bundle for the SD-card SPI master: transfer handshake plus card pins.
// The slave modport is the usd_spi block; master is the host and card side.
interface usd_spi_if;
  logic       fast;
  logic       csReq;
  logic       start;
  logic [7:0] txd;
  logic [7:0] rxd;
  logic       busy;
  logic       done;
  logic       cs;
  logic       ck;
  logic       mosi;
  logic       miso;

  modport master (
    output fast, csReq, start, txd, miso,
    input  rxd, busy, done, cs, ck, mosi
  );

  modport slave (
    input  fast, csReq, start, txd, miso,
    output rxd, busy, done, cs, ck, mosi
  );
endinterface

// File: rtl/usd_spi.sv
// SPI mode-0 byte master for SD cards with slow (init) and fast clock dividers.
// One byte per start; done strobes in the first idle cycle after the transfer.
module usd_spi #(
  parameter int unsigned SLOWDIV = 70,
  parameter int unsigned FASTDIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  usd_spi_if.slave    bus
);

  localparam int unsigned MaxDiv = (SLOWDIV > FASTDIV) ? SLOWDIV : FASTDIV;
  localparam int unsigned CntW   = (MaxDiv > 0) ? $clog2(MaxDiv + 1) : 1;
  localparam logic [CntW-1:0] SlowDivC = CntW'(SLOWDIV);
  localparam logic [CntW-1:0] FastDivC = CntW'(FASTDIV);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_div, w_div_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_tick_cnt, w_tick_cnt_d;
  logic            r_ck, w_ck_d;
  logic            r_mosi, w_mosi_d;
  logic [7:0]      r_tx, w_tx_d;
  logic [7:0]      r_rx, w_rx_d;
  logic [7:0]      r_rxd, w_rxd_d;
  logic            r_done, w_done_d;
  logic            r_cs, w_cs_d;
  logic            w_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_div      <= '0;
      r_cnt      <= '0;
      r_tick_cnt <= '0;
      r_ck       <= 1'b0;
      r_mosi     <= 1'b1;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rxd      <= '0;
      r_done     <= 1'b0;
      r_cs       <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_div      <= w_div_d;
      r_cnt      <= w_cnt_d;
      r_tick_cnt <= w_tick_cnt_d;
      r_ck       <= w_ck_d;
      r_mosi     <= w_mosi_d;
      r_tx       <= w_tx_d;
      r_rx       <= w_rx_d;
      r_rxd      <= w_rxd_d;
      r_done     <= w_done_d;
      r_cs       <= w_cs_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_div_d      = r_div;
    w_cnt_d      = r_cnt;
    w_tick_cnt_d = r_tick_cnt;
    w_ck_d       = r_ck;
    w_mosi_d     = r_mosi;
    w_tx_d       = r_tx;
    w_rx_d       = r_rx;
    w_rxd_d      = r_rxd;
    w_done_d     = 1'b0;
    w_cs_d       = r_cs;
    w_tick       = (r_state == StXfer) && (r_cnt == r_div);

    unique case (r_state)
      StIdle: begin
        w_cs_d   = ~bus.csReq;
        w_ck_d   = 1'b0;
        w_mosi_d = 1'b1;
        if (bus.start) begin
          w_state_d    = StXfer;
          w_div_d      = bus.fast ? FastDivC : SlowDivC;
          w_tx_d       = bus.txd;
          w_mosi_d     = bus.txd[7];
          w_cnt_d      = '0;
          w_tick_cnt_d = '0;
        end
      end
      StXfer: begin
        w_cnt_d = w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          w_tick_cnt_d = r_tick_cnt + 4'd1;
          w_ck_d       = ~r_ck;
          if (!r_ck) begin
            w_rx_d = {r_rx[6:0], bus.miso};
          end else if (r_tick_cnt == 4'd15) begin
            // Final falling edge: the byte is complete.
            w_state_d = StIdle;
            w_rxd_d   = r_rx;
            w_mosi_d  = 1'b1;
            w_done_d  = 1'b1;
          end else begin
            w_tx_d   = {r_tx[6:0], 1'b0};
            w_mosi_d = r_tx[6];
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.rxd  = r_rxd;
  assign bus.busy = (r_state == StXfer);
  assign bus.done = r_done;
  assign bus.cs   = r_cs;
  assign bus.ck   = r_ck;
  assign bus.mosi = r_mosi;

endmodule
